booth_wallace_multiplier: RTL and testbench



---
 rtl/booth_wallace_multiplier_pkg.sv | 58 +++++
 rtl/booth_wallace_multiplier_csa_3to2.sv | 16 +
 rtl/booth_wallace_multiplier.sv | 87 ++++++++
 tb/tb_booth_wallace_multiplier.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/booth_wallace_multiplier_pkg.sv
// Shared width, Booth digit flags and Wallace sizing helpers
// for the conv1d signed multiplier.
package booth_wallace_multiplier_pkg;

  localparam int WIDTH_DATA = 16;

  typedef struct packed {
    logic neg;
    logic sel2;
    logic sel1;
  } booth_t;

  localparam booth_t BOOTH_ZERO = '{neg: 1'b0, sel2: 1'b0, sel1: 1'b0};
  localparam booth_t BOOTH_POS1 = '{neg: 1'b0, sel2: 1'b0, sel1: 1'b1};
  localparam booth_t BOOTH_POS2 = '{neg: 1'b0, sel2: 1'b1, sel1: 1'b0};
  localparam booth_t BOOTH_NEG1 = '{neg: 1'b1, sel2: 1'b0, sel1: 1'b1};
  localparam booth_t BOOTH_NEG2 = '{neg: 1'b1, sel2: 1'b1, sel1: 1'b0};

  function automatic booth_t booth_decode(input logic [2:0] trip);
    booth_t d;
    d = BOOTH_ZERO;
    unique case (trip)
      3'b000: d = BOOTH_ZERO;
      3'b001: d = BOOTH_POS1;
      3'b010: d = BOOTH_POS1;
      3'b011: d = BOOTH_POS2;
      3'b100: d = BOOTH_NEG2;
      3'b101: d = BOOTH_NEG1;
      3'b110: d = BOOTH_NEG1;
      3'b111: d = BOOTH_ZERO;
      default: d = BOOTH_ZERO;
    endcase
    return d;
  endfunction

  // Rows left after a given number of 3:2 levels.
  function automatic int wallace_rows(input int n0, input int lvl);
    int r;
    r = n0;
    for (int k = 0; k < lvl; k++) begin
      r = 2 * (r / 3) + (r % 3);
    end
    return r;
  endfunction

  function automatic int wallace_levels(input int n0);
    int r;
    int l;
    r = n0;
    l = 0;
    while (r > 2) begin
      r = 2 * (r / 3) + (r % 3);
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/booth_wallace_multiplier_csa_3to2.sv
// Bit-vector full-adder row: three rows in, sum and
// unshifted carry rows out.
module csa_3to2 #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_sum,
  output logic [W-1:0] o_carry
);

  assign o_sum   = i_a ^ i_b ^ i_c;
  assign o_carry = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/booth_wallace_multiplier.sv
// Radix-4 Booth / Wallace-tree signed multiplier with a
// single registered product stage.
module booth_wallace_multiplier
  import booth_wallace_multiplier_pkg::*;
#(
  parameter int WIDTH_DATA = booth_wallace_multiplier_pkg::WIDTH_DATA
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [WIDTH_DATA-1:0]  weight,
  input  logic signed [WIDTH_DATA-1:0]  feature,
  output logic signed [2*WIDTH_DATA-1:0] result_out
);

  localparam int PW  = 2 * WIDTH_DATA;
  localparam int NPP = WIDTH_DATA / 2;
  localparam int NR  = NPP + 1;
  localparam int NL  = wallace_levels(NR);

  logic [WIDTH_DATA:0] w_wext;
  logic [PW-1:0]       w_fext;
  logic [PW-1:0]       w_corr;
  logic [PW-1:0]       w_lvl [0:NL][0:NR-1];
  logic [PW-1:0]       r_result;

  assign w_wext = {weight, 1'b0};
  assign w_fext = {{WIDTH_DATA{feature[WIDTH_DATA-1]}}, feature};

  // Negation is ~m here; the +1 lands in the correction row at bit 2i.
  for (genvar i = 0; i < NPP; i++) begin : g_pp
    booth_t        w_dig;
    logic [PW-1:0] w_mag;
    logic [PW-1:0] w_inv;

    assign w_dig = booth_decode(w_wext[2*i+2:2*i]);
    assign w_mag = w_dig.sel2 ? (w_fext << 1) :
                   w_dig.sel1 ? w_fext : '0;
    assign w_inv = w_dig.neg ? ~w_mag : w_mag;
    assign w_lvl[0][i] = w_inv << (2 * i);
    assign w_corr[2*i] = w_dig.neg;
    assign w_corr[2*i+1] = 1'b0;
  end

  assign w_corr[PW-1:2*NPP] = '0;
  assign w_lvl[0][NPP] = w_corr;

  for (genvar l = 0; l < NL; l++) begin : g_lvl
    localparam int R   = wallace_rows(NR, l);
    localparam int G   = R / 3;
    localparam int REM = R % 3;

    for (genvar g = 0; g < G; g++) begin : g_csa
      logic [PW-1:0] w_sum;
      logic [PW-1:0] w_cy;

      csa_3to2 #(.W(PW)) u_csa (
        .i_a     (w_lvl[l][3*g]),
        .i_b     (w_lvl[l][3*g+1]),
        .i_c     (w_lvl[l][3*g+2]),
        .o_sum   (w_sum),
        .o_carry (w_cy)
      );

      assign w_lvl[l+1][2*g]   = w_sum;
      assign w_lvl[l+1][2*g+1] = {w_cy[PW-2:0], 1'b0};
    end

    for (genvar j = 2 * G; j < NR; j++) begin : g_pass
      if (j < 2 * G + REM) begin : g_keep
        assign w_lvl[l+1][j] = w_lvl[l][3*G+j-2*G];
      end else begin : g_zero
        assign w_lvl[l+1][j] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
    end else begin
      r_result <= w_lvl[NL][0] + w_lvl[NL][1];
    end
  end

  assign result_out = r_result;

endmodule

// File: tb/tb_booth_wallace_multiplier.sv
// Self-checking bench: directed corners plus random pairs
// against a plain signed-product reference.
module tb_booth_wallace_multiplier;

  localparam int W = 16;

  logic                  clk;
  logic                  rst;
  logic signed [W-1:0]   weight;
  logic signed [W-1:0]   feature;
  logic signed [2*W-1:0] result_out;

  int n_tests;
  int n_fail;

  booth_wallace_multiplier #(.WIDTH_DATA(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .weight     (weight),
    .feature    (feature),
    .result_out (result_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input int a, input int b);
    int p;
    p = a * b;
    return p;
  endfunction

  task automatic drive(input int w, input int f);
    @(negedge clk);
    weight  = W'(w);
    feature = W'(f);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    weight = 16'sd123;
    feature = 16'sd45;
    #2;
    n_tests++;
    if (result_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_init got %h want %h", result_out, 32'h0);
    end
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (result_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_held got %h want %h", result_out, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    drive(9, 7);
    n_tests++;
    if (result_out !== 32'h0000003F) begin
      n_fail++;
      $display("FAIL basic got %h want %h", result_out, 32'h3F);
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (result_out !== 32'h0000003F) begin
      n_fail++;
      $display("FAIL basic_hold got %h want %h", result_out, 32'h3F);
    end
  endtask

  task automatic test_signs;
    int tw [4] = '{-9, 9, -9, 9};
    int tf [4] = '{7, -7, -7, 7};
    logic [31:0] te [4] = '{32'hFFFFFFC1, 32'hFFFFFFC1,
                            32'h0000003F, 32'h0000003F};
    for (int i = 0; i < 4; i++) begin
      drive(tw[i], tf[i]);
      n_tests++;
      if (result_out !== te[i]) begin
        n_fail++;
        $display("FAIL signs[%0d] got %h want %h", i, result_out, te[i]);
      end
    end
  endtask

  task automatic test_extremes;
    int tw [4] = '{-32768, -32768, 32767, 32767};
    int tf [4] = '{-32768, 32767, 32767, -32768};
    logic [31:0] te [4] = '{32'h40000000, 32'hC0008000,
                            32'h3FFF0001, 32'hC0008000};
    for (int i = 0; i < 4; i++) begin
      drive(tw[i], tf[i]);
      n_tests++;
      if (result_out !== te[i]) begin
        n_fail++;
        $display("FAIL extreme[%0d] got %h want %h", i, result_out, te[i]);
      end
    end
  endtask

  task automatic test_identity;
    int f;
    logic [31:0] e;
    for (int i = 0; i < 6; i++) begin
      f = int'($urandom_range(0, 65535)) - 32768;
      if (i == 0) f = -32768;
      drive(0, f);
      n_tests++;
      if (result_out !== 32'h0) begin
        n_fail++;
        $display("FAIL zero f=%0d got %h want 0", f, result_out);
      end
      drive(1, f);
      e = f;
      n_tests++;
      if (result_out !== e) begin
        n_fail++;
        $display("FAIL one f=%0d got %h want %h", f, result_out, e);
      end
      drive(-1, f);
      e = -f;
      n_tests++;
      if (result_out !== e) begin
        n_fail++;
        $display("FAIL neg1 f=%0d got %h want %h", f, result_out, e);
      end
    end
  endtask

  task automatic test_async_reset;
    drive(-1234, 567);
    n_tests++;
    if (result_out !== ref_mul(-1234, 567)) begin
      n_fail++;
      $display("FAIL pre_rst got %h want %h", result_out,
               ref_mul(-1234, 567));
    end
    @(negedge clk);
    weight  = 16'sd321;
    feature = -16'sd77;
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (result_out !== 32'h0) begin
      n_fail++;
      $display("FAIL async_rst got %h want 0", result_out);
    end
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (result_out !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_hold got %h want 0", result_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (result_out !== ref_mul(321, -77)) begin
      n_fail++;
      $display("FAIL post_rst got %h want %h", result_out,
               ref_mul(321, -77));
    end
  endtask

  task automatic test_back_to_back;
    int tw [5] = '{3, -100, 32767, -2, 0};
    int tf [5] = '{5, 200, -1, -32768, 99};
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      weight  = W'(tw[i]);
      feature = W'(tf[i]);
      @(posedge clk);
      #1;
      n_tests++;
      if (result_out !== ref_mul(tw[i], tf[i])) begin
        n_fail++;
        $display("FAIL b2b[%0d] got %h want %h", i, result_out,
                 ref_mul(tw[i], tf[i]));
      end
    end
  endtask

  task automatic test_random;
    int a;
    int b;
    int bad;
    bad = 0;
    @(negedge clk);
    for (int i = 0; i < 12000; i++) begin
      a = int'($urandom_range(0, 65535)) - 32768;
      b = int'($urandom_range(0, 65535)) - 32768;
      weight  = W'(a);
      feature = W'(b);
      @(posedge clk);
      #1;
      n_tests++;
      if (result_out !== ref_mul(a, b)) begin
        n_fail++;
        bad++;
        if (bad <= 10)
          $display("FAIL random w=%0d f=%0d got %h want %h",
                   a, b, result_out, ref_mul(a, b));
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    weight  = '0;
    feature = '0;
    test_reset;
    test_basic;
    test_signs;
    test_extremes;
    test_identity;
    test_async_reset;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
